dcache_data_store_assoc: RTL and testbench
==========================================

# dcache_data_store_assoc

Set-associative data store for the write-through L1 data cache: NUM_WAYS independent 1R1W byte-enabled line arrays behind one read port, one store-hit write port and one beat-serial refill port. Refill beats from the memory side are assembled into a full line and committed in one write. Same-cycle read/write collisions are forwarded, and reads to a line under refill are stalled. Sits between the cache controller/tag compare and the per-way block RAMs, replacing the single-array data store.

## Interface
- DATA_WIDTH, 128, cache line width in bits; multiple of BEAT_WIDTH and of 8
- NUM_WORDS, 256, sets per way
- NUM_WAYS, 4, associativity; ≥1
- BEAT_WIDTH, 64, refill beat width; BEATS = DATA_WIDTH/BEAT_WIDTH ≥ 2
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- rd_req_i  in  1  read request
- rd_addr_i  in  $clog2(NUM_WORDS)  read set index
- rd_way_i  in  $clog2(NUM_WAYS) (min 1)  read way
- rd_gnt_o  out  1  read accepted this cycle
- rd_valid_o  out  1  rd_data_o valid (one cycle after grant)
- rd_data_o  out  DATA_WIDTH  read line, held until next grant
- wr_req_i  in  1  store-hit write request
- wr_addr_i, wr_way_i  in  as read  write set/way
- wr_be_i  in  DATA_WIDTH/8  byte enables
- wr_data_i  in  DATA_WIDTH  write data (byte lanes aligned to line)
- wr_gnt_o  out  1  write performed this cycle
- refill_valid_i  in  1  refill beat valid
- refill_ready_o  out  1  refill beat accepted when both high
- refill_addr_i, refill_way_i  in  as read  target; sampled on first beat only
- refill_data_i  in  BEAT_WIDTH  beat data
- refill_done_o  out  1  one-cycle pulse when line committed

## Operation
- Refill FSM: IDLE → FILL on first accepted beat (latch addr/way, beat 0); FILL counts beats; accepting beat BEATS-1 → COMMIT; COMMIT writes full line (all bytes) to latched set/way, pulses refill_done_o, → IDLE.
- Beat k lands in line bits [k*BEAT_WIDTH +: BEAT_WIDTH]; counter width $clog2(BEATS), wraps to 0 at commit.
- refill_ready_o = 1 in IDLE and FILL, 0 in COMMIT.
- Write port arbitration: COMMIT has priority; wr_gnt_o = wr_req_i && state != COMMIT. Ungranted write must be held by requester.
- Write with wr_be_i == 0 is granted, no array change.
- Read: rd_gnt_o = rd_req_i && !(state ∈ {FILL, COMMIT} && rd_addr_i/rd_way_i equal latched refill addr/way). Reads to other lines proceed during refill.
- Forwarding: read and granted store write to same set/way in the same cycle → rd_data_o returns old line with enabled bytes replaced by wr_data_i (write-first). Different set/way: no interaction.
- Commit and read of a different line in the same cycle both proceed.
- Array contents not reset; undefined until written.

## Timing
- Reset values: rd_valid_o 0, rd_data_o 0, rd_gnt_o/wr_gnt_o follow inputs (comb.), refill_ready_o 1, refill_done_o 0, FSM IDLE, beat counter 0.
- Read latency 1: grant at cycle t → rd_valid_o and rd_data_o at t+1; rd_valid_o low if no grant at t; rd_data_o keeps last value.
- Store write visible to a read granted at t+1 or later; at t via forwarding.
- Refill: BEATS accepted beats + 1 COMMIT cycle; refill_done_o in COMMIT; committed line readable from the following cycle, stall releases in the cycle after COMMIT.
- Back-to-back refills: new first beat accepted the cycle after COMMIT.
- Reset mid-refill: partial line discarded, no array write, no done pulse.

## Structure
- dcache_pkg: BEATS, set-index/way-index widths, refill state enum (IDLE/FILL/COMMIT).
- Sub-module dcache_data_way_ram: 1R1W, synchronous read, per-byte write enable, DATA_WIDTH × NUM_WORDS; instantiated NUM_WAYS times, block-RAM inferable. Read-way mux, forwarding merge and output register live in the top.

## Test plan
- Refill way 2 set 0x10 with beats 0xAAAA…/0xBBBB… → refill_done_o pulses once after 2 beats; read → line {0xBBBB…,0xAAAA…}, rd_valid_o exactly 1 cycle after grant.
- Store wr_be_i=0x000F, data 0x11223344 to set 0x10 way 2, same-cycle read → rd_data_o low word 0x11223344, other bytes unchanged; re-read next cycle matches.
- Read to set 0x10 way 2 during FILL → rd_gnt_o 0 until after COMMIT; read to set 0x11 way 2 in same window → granted, correct data.
- wr_req_i held across COMMIT cycle → wr_gnt_o 0 in COMMIT, 1 next cycle; final line = refill data with store bytes applied.
- Assert rst_ni after first refill beat → no done pulse, set unchanged, refill_ready_o 1, next refill completes normally.
- Random reads/writes/refills across 4 ways vs. scoreboard model, including refill_valid_i gaps and back-to-back refills.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative L1 data store.
// Default geometry matches the write-through L1 configuration.
package dcache_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 128;
   localparam int unsigned DEF_NUM_WORDS  = 256;
   localparam int unsigned DEF_NUM_WAYS   = 4;
   localparam int unsigned DEF_BEAT_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      COMMIT = 2'd2
   } refill_state_e;

   // Index width that stays at least one bit for single-entry dimensions.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dcache_data_way_ram.sv
// One way of the data store: 1R1W line array with per-byte write enables
// and a registered read port, written in the block-RAM inference template.
module dcache_data_way_ram #(
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned NUM_WORDS  = 256,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_WORDS)
) (
   input  logic                    clk,
   input  logic                    rd_en,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data
);

   localparam int unsigned BE_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   // Read-before-write on a shared address; the top merges same-cycle stores.
   always_ff @(posedge clk) begin
      for (int b = 0; b < BE_W; b++) begin
         if (wr_be[b]) begin
            mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/dcache_data_store_assoc.sv
// Set-associative L1 data store: per-way line RAMs behind one read port, one
// store-hit write port and a beat-serial refill port that commits whole lines.
module dcache_data_store_assoc
   import dcache_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS,
   parameter int unsigned NUM_WAYS   = DEF_NUM_WAYS,
   parameter int unsigned BEAT_WIDTH = DEF_BEAT_WIDTH,
   parameter int unsigned AW         = $clog2(NUM_WORDS),
   parameter int unsigned WW         = clog2_min1(NUM_WAYS)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    rd_req_i,
   input  logic [AW-1:0]           rd_addr_i,
   input  logic [WW-1:0]           rd_way_i,
   output logic                    rd_gnt_o,
   output logic                    rd_valid_o,
   output logic [DATA_WIDTH-1:0]   rd_data_o,
   input  logic                    wr_req_i,
   input  logic [AW-1:0]           wr_addr_i,
   input  logic [WW-1:0]           wr_way_i,
   input  logic [DATA_WIDTH/8-1:0] wr_be_i,
   input  logic [DATA_WIDTH-1:0]   wr_data_i,
   output logic                    wr_gnt_o,
   input  logic                    refill_valid_i,
   output logic                    refill_ready_o,
   input  logic [AW-1:0]           refill_addr_i,
   input  logic [WW-1:0]           refill_way_i,
   input  logic [BEAT_WIDTH-1:0]   refill_data_i,
   output logic                    refill_done_o
);

   localparam int unsigned BEATS = DATA_WIDTH / BEAT_WIDTH;
   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned CW    = clog2_min1(BEATS);

   refill_state_e         state_reg, state_next;
   logic [CW-1:0]         beat_cnt_reg;
   logic [AW-1:0]         refill_addr_reg;
   logic [WW-1:0]         refill_way_reg;
   logic [DATA_WIDTH-1:0] line_reg;

   logic                  commit_en;
   logic                  beat_accept;
   logic                  last_beat;
   logic                  rd_stall;
   logic                  fwd_hit;

   logic                  rd_valid_reg;
   logic [WW-1:0]         rd_way_reg;
   logic [BE_W-1:0]       fwd_be_reg;
   logic [DATA_WIDTH-1:0] fwd_data_reg;
   logic [DATA_WIDTH-1:0] hold_reg;
   logic [DATA_WIDTH-1:0] merged_data;
   logic [DATA_WIDTH-1:0] way_rd_data [NUM_WAYS];

   assign beat_accept = refill_valid_i && refill_ready_o;
   assign last_beat   = (state_reg == FILL) && (beat_cnt_reg == CW'(BEATS - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (beat_accept) state_next = FILL;
         FILL:    if (beat_accept && last_beat) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      refill_ready_o = 1'b1;
      refill_done_o  = 1'b0;
      commit_en      = 1'b0;
      if (state_reg == COMMIT) begin
         refill_ready_o = 1'b0;
         refill_done_o  = 1'b1;
         commit_en      = 1'b1;
      end
   end

   // Target is captured on the first beat only; later beats just fill lanes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_cnt_reg    <= '0;
         refill_addr_reg <= '0;
         refill_way_reg  <= '0;
         line_reg        <= '0;
      end else if (beat_accept) begin
         if (state_reg == IDLE) begin
            refill_addr_reg <= refill_addr_i;
            refill_way_reg  <= refill_way_i;
         end
         line_reg[beat_cnt_reg*BEAT_WIDTH +: BEAT_WIDTH] <= refill_data_i;
         beat_cnt_reg <= last_beat ? '0 : beat_cnt_reg + 1'b1;
      end
   end

   assign rd_stall = (state_reg != IDLE) && (rd_addr_i == refill_addr_reg)
                     && (rd_way_i == refill_way_reg);
   assign rd_gnt_o = rd_req_i && !rd_stall;
   assign wr_gnt_o = wr_req_i && !commit_en;
   assign fwd_hit  = rd_gnt_o && wr_gnt_o && (rd_addr_i == wr_addr_i) && (rd_way_i == wr_way_i);

   generate
      for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
         logic [BE_W-1:0]       way_be;
         logic [AW-1:0]         way_addr;
         logic [DATA_WIDTH-1:0] way_data;

         always_comb begin
            way_be   = '0;
            way_addr = wr_addr_i;
            way_data = wr_data_i;
            if (commit_en && (refill_way_reg == WW'(gi))) begin
               way_be   = '1;
               way_addr = refill_addr_reg;
               way_data = line_reg;
            end else if (wr_gnt_o && (wr_way_i == WW'(gi))) begin
               way_be = wr_be_i;
            end
         end

         dcache_data_way_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WORDS  (NUM_WORDS),
            .ADDR_WIDTH (AW)
         ) u_ram (
            .clk     (clk_i),
            .rd_en   (rd_gnt_o),
            .rd_addr (rd_addr_i),
            .rd_data (way_rd_data[gi]),
            .wr_be   (way_be),
            .wr_addr (way_addr),
            .wr_data (way_data)
         );
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_valid_reg <= 1'b0;
         rd_way_reg   <= '0;
         fwd_be_reg   <= '0;
         fwd_data_reg <= '0;
         hold_reg     <= '0;
      end else begin
         rd_valid_reg <= rd_gnt_o;
         if (rd_gnt_o) begin
            rd_way_reg   <= rd_way_i;
            fwd_be_reg   <= fwd_hit ? wr_be_i : '0;
            fwd_data_reg <= wr_data_i;
         end
         if (rd_valid_reg) begin
            hold_reg <= merged_data;
         end
      end
   end

   // The RAM returns the pre-write line; overlay any same-cycle store bytes.
   always_comb begin
      merged_data = way_rd_data[rd_way_reg];
      for (int b = 0; b < BE_W; b++) begin
         if (fwd_be_reg[b]) begin
            merged_data[b*8 +: 8] = fwd_data_reg[b*8 +: 8];
         end
      end
   end

   assign rd_valid_o = rd_valid_reg;
   assign rd_data_o  = rd_valid_reg ? merged_data : hold_reg;

endmodule

// File: tb/tb_dcache_data_store_assoc.sv
// Self-checking bench for dcache_data_store_assoc: directed scenario tasks plus
// a negedge scoreboard that models grants, refill handshake and read data.
module tb_dcache_data_store_assoc;

   localparam int DW    = 128;
   localparam int NW    = 256;
   localparam int NWAY  = 4;
   localparam int BW    = 64;
   localparam int BEATS = DW / BW;
   localparam int BEW   = DW / 8;

   logic           clk;
   logic           rst_ni;
   logic           rd_req;
   logic [7:0]     rd_addr;
   logic [1:0]     rd_way;
   logic           rd_gnt;
   logic           rd_valid;
   logic [DW-1:0]  rd_data;
   logic           wr_req;
   logic [7:0]     wr_addr;
   logic [1:0]     wr_way;
   logic [BEW-1:0] wr_be;
   logic [DW-1:0]  wr_data;
   logic           wr_gnt;
   logic           refill_valid;
   logic           refill_ready;
   logic [7:0]     refill_addr;
   logic [1:0]     refill_way;
   logic [BW-1:0]  refill_data;
   logic           refill_done;

   int checks   = 0;
   int failures = 0;

   dcache_data_store_assoc #(
      .DATA_WIDTH (DW),
      .NUM_WORDS  (NW),
      .NUM_WAYS   (NWAY),
      .BEAT_WIDTH (BW)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .rd_req_i       (rd_req),
      .rd_addr_i      (rd_addr),
      .rd_way_i       (rd_way),
      .rd_gnt_o       (rd_gnt),
      .rd_valid_o     (rd_valid),
      .rd_data_o      (rd_data),
      .wr_req_i       (wr_req),
      .wr_addr_i      (wr_addr),
      .wr_way_i       (wr_way),
      .wr_be_i        (wr_be),
      .wr_data_i      (wr_data),
      .wr_gnt_o       (wr_gnt),
      .refill_valid_i (refill_valid),
      .refill_ready_o (refill_ready),
      .refill_addr_i  (refill_addr),
      .refill_way_i   (refill_way),
      .refill_data_i  (refill_data),
      .refill_done_o  (refill_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model / scoreboard ----------------
   logic [DW-1:0] model [NWAY][NW];
   logic [DW-1:0] sb_q[$];
   bit            pend;
   logic [DW-1:0] exp_hold;
   logic [DW-1:0] exp_line;
   bit            m_busy, m_commit;
   int            m_beat;
   logic [7:0]    m_addr;
   logic [1:0]    m_way;
   logic [DW-1:0] m_line;
   bit            e_rgnt, e_wgnt;

   function automatic logic [DW-1:0] merge_be(input logic [DW-1:0] old_line,
                                              input logic [DW-1:0] new_data,
                                              input logic [BEW-1:0] be);
      logic [DW-1:0] r;
      r = old_line;
      for (int b = 0; b < BEW; b++)
         if (be[b]) r[b*8 +: 8] = new_data[b*8 +: 8];
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst_ni) begin
         sb_q.delete();
         pend     = 0;
         exp_hold = '0;
         m_busy   = 0;
         m_commit = 0;
         m_beat   = 0;
      end else begin
         checks++;
         if (rd_valid !== pend) begin
            failures++;
            $display("FAIL sb_rd_valid: got %b expected %b at %0t", rd_valid, pend, $time);
         end
         if (pend && sb_q.size() > 0) exp_hold = sb_q.pop_front();
         checks++;
         if (rd_data !== exp_hold) begin
            failures++;
            $display("FAIL sb_rd_data: got %h expected %h at %0t", rd_data, exp_hold, $time);
         end
         e_rgnt = rd_req && !(m_busy && rd_addr == m_addr && rd_way == m_way);
         e_wgnt = wr_req && !m_commit;
         checks++;
         if (rd_gnt !== e_rgnt) begin
            failures++;
            $display("FAIL sb_rd_gnt: got %b expected %b at %0t", rd_gnt, e_rgnt, $time);
         end
         checks++;
         if (wr_gnt !== e_wgnt) begin
            failures++;
            $display("FAIL sb_wr_gnt: got %b expected %b at %0t", wr_gnt, e_wgnt, $time);
         end
         checks++;
         if (refill_ready !== !m_commit || refill_done !== m_commit) begin
            failures++;
            $display("FAIL sb_refill: got ready=%b done=%b expected ready=%b done=%b at %0t",
                     refill_ready, refill_done, !m_commit, m_commit, $time);
         end
         if (e_rgnt) begin
            exp_line = model[rd_way][rd_addr];
            if (e_wgnt && wr_addr == rd_addr && wr_way == rd_way)
               exp_line = merge_be(exp_line, wr_data, wr_be);
            sb_q.push_back(exp_line);
         end
         pend = e_rgnt;
         if (e_wgnt) model[wr_way][wr_addr] = merge_be(model[wr_way][wr_addr], wr_data, wr_be);
         if (m_commit) begin
            model[m_way][m_addr] = m_line;
            m_commit = 0;
            m_busy   = 0;
         end else if (refill_valid) begin
            if (!m_busy) begin
               m_addr = refill_addr;
               m_way  = refill_way;
               m_beat = 0;
               m_busy = 1;
            end
            m_line[m_beat*BW +: BW] = refill_data;
            m_beat++;
            if (m_beat == BEATS) m_commit = 1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rd_req = 0; rd_addr = '0; rd_way = '0;
      wr_req = 0; wr_addr = '0; wr_way = '0; wr_be = '0; wr_data = '0;
      refill_valid = 0; refill_addr = '0; refill_way = '0; refill_data = '0;
   endtask

   localparam logic [BW-1:0] BEAT_A = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [BW-1:0] BEAT_B = 64'hBBBB_BBBB_BBBB_BBBB;
   localparam logic [BW-1:0] BEAT_D = 64'hD0D1_D2D3_D4D5_D6D7;
   localparam logic [BW-1:0] BEAT_E = 64'hE0E1_E2E3_E4E5_E6E7;
   localparam logic [BW-1:0] BEAT_F = 64'hF0F0_F0F0_F0F0_F0F0;
   localparam logic [BW-1:0] BEAT_G = 64'h6666_7777_8888_9999;
   localparam logic [DW-1:0] LINE_C = 128'hC0C1_C2C3_C4C5_C6C7_C8C9_CACB_CCCD_CECF;

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      rst_ni = 0;
      rd_req = 1; rd_addr = 8'h05; rd_way = 2'd1;
      wr_req = 1; wr_be = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
      checks++;
      if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
      checks++;
      if (refill_ready !== 1'b1 || refill_done !== 1'b0) begin
         failures++; $display("FAIL reset_refill: got ready=%b done=%b expected 1/0", refill_ready, refill_done);
      end
      checks++;
      if (rd_gnt !== 1'b1 || wr_gnt !== 1'b1) begin
         failures++; $display("FAIL reset_gnt: got rd=%b wr=%b expected 1/1", rd_gnt, wr_gnt);
      end
      idle_inputs();
      @(posedge clk);
      #1 rst_ni = 1;
      tick();
   endtask

   task automatic test_refill();
      refill_valid = 1; refill_addr = 8'h10; refill_way = 2'd2; refill_data = BEAT_A;
      tick();
      refill_addr = 8'h55; refill_way = 2'd0; refill_data = BEAT_B;
      tick();
      refill_valid = 0; refill_addr = '0; refill_way = '0;
      @(negedge clk);
      checks++;
      if (refill_done !== 1'b1 || refill_ready !== 1'b0) begin
         failures++; $display("FAIL refill_commit: got done=%b ready=%b expected 1/0", refill_done, refill_ready);
      end
      tick();
      rd_req = 1; rd_addr = 8'h10; rd_way = 2'd2;
      @(negedge clk);
      checks++;
      if (refill_done !== 1'b0 || rd_gnt !== 1'b1) begin
         failures++; $display("FAIL refill_after: got done=%b rd_gnt=%b expected 0/1", refill_done, rd_gnt);
      end
      tick();
      rd_req = 0;
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== {BEAT_B, BEAT_A}) begin
         failures++; $display("FAIL refill_read: got valid=%b data=%h expected 1/%h", rd_valid, rd_data, {BEAT_B, BEAT_A});
      end
      tick();
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== {BEAT_B, BEAT_A}) begin
         failures++; $display("FAIL refill_hold: got valid=%b data=%h expected 0/%h", rd_valid, rd_data, {BEAT_B, BEAT_A});
      end
      tick();
   endtask

   task automatic test_store_forward();
      logic [DW-1:0] exp;
      exp = {BEAT_B, 32'hAAAA_AAAA, 32'h1122_3344};
      wr_req = 1; wr_addr = 8'h10; wr_way = 2'd2; wr_be = 16'h000F;
      wr_data = {96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 32'h1122_3344};
      rd_req = 1; rd_addr = 8'h10; rd_way = 2'd2;
      tick();
      wr_req = 0; wr_be = '0;
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
         failures++; $display("FAIL store_forward: got %h expected %h", rd_data, exp);
      end
      tick();
      rd_req = 0;
      @(negedge clk);
      checks++;
      if (rd_data !== exp) begin
         failures++; $display("FAIL store_reread: got %h expected %h", rd_data, exp);
      end
      tick();
   endtask

   task automatic test_read_stall();
      wr_req = 1; wr_addr = 8'h11; wr_way = 2'd2; wr_be = '1; wr_data = LINE_C;
      tick();
      idle_inputs();
      refill_valid = 1; refill_addr = 8'h10; refill_way = 2'd2; refill_data = BEAT_D;
      tick();
      refill_valid = 0;
      rd_req = 1; rd_addr = 8'h10; rd_way = 2'd2;
      @(negedge clk);
      checks++;
      if (rd_gnt !== 1'b0) begin failures++; $display("FAIL stall_fill: got rd_gnt=%b expected 0", rd_gnt); end
      tick();
      refill_valid = 1; refill_data = BEAT_E;
      rd_addr = 8'h11;
      @(negedge clk);
      checks++;
      if (rd_gnt !== 1'b1) begin failures++; $display("FAIL stall_other: got rd_gnt=%b expected 1", rd_gnt); end
      tick();
      refill_valid = 0;
      rd_addr = 8'h10;
      @(negedge clk);
      checks++;
      if (rd_gnt !== 1'b0 || rd_data !== LINE_C || refill_done !== 1'b1) begin
         failures++; $display("FAIL stall_commit: got gnt=%b done=%b data=%h expected 0/1/%h", rd_gnt, refill_done, rd_data, LINE_C);
      end
      tick();
      @(negedge clk);
      checks++;
      if (rd_gnt !== 1'b1) begin failures++; $display("FAIL stall_release: got rd_gnt=%b expected 1", rd_gnt); end
      tick();
      rd_req = 0;
      @(negedge clk);
      checks++;
      if (rd_data !== {BEAT_E, BEAT_D}) begin
         failures++; $display("FAIL stall_data: got %h expected %h", rd_data, {BEAT_E, BEAT_D});
      end
      tick();
   endtask

   task automatic test_write_commit();
      logic [DW-1:0] exp;
      exp = {BEAT_G, 32'h5566_7788, 32'hF0F0_F0F0};
      refill_valid = 1; refill_addr = 8'h20; refill_way = 2'd1; refill_data = BEAT_F;
      tick();
      refill_data = BEAT_G;
      tick();
      refill_valid = 0;
      wr_req = 1; wr_addr = 8'h20; wr_way = 2'd1; wr_be = 16'h00F0;
      wr_data = 128'h0000_0000_0000_0000_5566_7788_0000_0000;
      @(negedge clk);
      checks++;
      if (wr_gnt !== 1'b0) begin failures++; $display("FAIL wc_commit_gnt: got %b expected 0", wr_gnt); end
      tick();
      @(negedge clk);
      checks++;
      if (wr_gnt !== 1'b1) begin failures++; $display("FAIL wc_next_gnt: got %b expected 1", wr_gnt); end
      tick();
      idle_inputs();
      rd_req = 1; rd_addr = 8'h20; rd_way = 2'd1;
      tick();
      rd_req = 0;
      @(negedge clk);
      checks++;
      if (rd_data !== exp) begin failures++; $display("FAIL wc_line: got %h expected %h", rd_data, exp); end
      tick();
   endtask

   task automatic test_reset_mid_refill();
      refill_valid = 1; refill_addr = 8'h10; refill_way = 2'd2; refill_data = 64'h1234_5678_9ABC_DEF0;
      tick();
      refill_valid = 0;
      rst_ni = 0;
      @(negedge clk);
      checks++;
      if (refill_ready !== 1'b1 || refill_done !== 1'b0) begin
         failures++; $display("FAIL rst_mid_state: got ready=%b done=%b expected 1/0", refill_ready, refill_done);
      end
      @(posedge clk);
      #1 rst_ni = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (refill_done !== 1'b0) begin failures++; $display("FAIL rst_mid_done: got %b expected 0", refill_done); end
         tick();
      end
      rd_req = 1; rd_addr = 8'h10; rd_way = 2'd2;
      tick();
      rd_req = 0;
      @(negedge clk);
      checks++;
      if (rd_data !== {BEAT_E, BEAT_D}) begin
         failures++; $display("FAIL rst_mid_line: got %h expected %h", rd_data, {BEAT_E, BEAT_D});
      end
      tick();
      refill_valid = 1; refill_addr = 8'h30; refill_way = 2'd3; refill_data = BEAT_A;
      tick();
      refill_data = BEAT_F;
      tick();
      refill_valid = 0;
      @(negedge clk);
      checks++;
      if (refill_done !== 1'b1) begin failures++; $display("FAIL rst_mid_next_done: got %b expected 1", refill_done); end
      tick();
      rd_req = 1; rd_addr = 8'h30; rd_way = 2'd3;
      tick();
      rd_req = 0;
      @(negedge clk);
      checks++;
      if (rd_data !== {BEAT_F, BEAT_A}) begin
         failures++; $display("FAIL rst_mid_next_line: got %h expected %h", rd_data, {BEAT_F, BEAT_A});
      end
      tick();
   endtask

   task automatic test_random();
      for (int s = 0; s < 8; s++) begin
         for (int w = 0; w < NWAY; w++) begin
            wr_req = 1; wr_addr = 8'(s); wr_way = 2'(w); wr_be = '1;
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
         end
      end
      idle_inputs();
      for (int c = 0; c < 400; c++) begin
         rd_req  = 1'($urandom % 2);
         rd_addr = 8'($urandom % 8);
         rd_way  = 2'($urandom % 4);
         wr_req  = 1'($urandom % 2);
         wr_addr = 8'($urandom % 8);
         wr_way  = 2'($urandom % 4);
         if ($urandom % 4 == 0) begin
            wr_addr = rd_addr;
            wr_way  = rd_way;
         end
         wr_be   = 16'($urandom);
         wr_data = {$urandom, $urandom, $urandom, $urandom};
         refill_valid = ($urandom % 3) != 0;
         refill_addr  = 8'($urandom % 8);
         refill_way   = 2'($urandom % 4);
         refill_data  = {$urandom, $urandom};
         tick();
      end
      idle_inputs();
      repeat (4) tick();
   endtask

   initial begin
      test_reset();
      test_refill();
      test_store_forward();
      test_read_stall();
      test_write_commit();
      test_reset_mid_refill();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
